// File: rtl/request_encoder_pkg.sv
// Purpose: shared constants and state type for the round-robin request encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package request_encoder_pkg;

   localparam int N_DEFAULT  = 8;
   localparam int AW_DEFAULT = $clog2(N_DEFAULT);

   // Output register occupancy.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/request_encoder_rr_pick.sv
// Purpose: combinational round-robin first-one finder, searching from start upward with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
// Ports: vec (N requests), start (AW search origin, must be < N) -> idx (AW), found.
module rr_pick #(
   parameter int N  = 8,
   parameter int AW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   input  logic [AW-1:0] start,
   output logic [AW-1:0] idx,
   output logic          found
);

   logic [N-1:0] rot;
   logic [AW:0]  sum;

   always_comb begin
      // Rotate so bit 0 of rot corresponds to position start; the first set
      // bit of rot is then the round-robin winner at offset k from start.
      rot   = N'({vec, vec} >> start);
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, start} + (AW+1)'(k);
            // start < N and k < N, so one subtraction is enough to wrap.
            if (sum >= (AW+1)'(N)) begin
               sum = sum - (AW+1)'(N);
            end
            idx = sum[AW-1:0];
         end
      end
   end

endmodule

// File: rtl/request_encoder.sv
// Purpose: latch sticky request events and emit them one at a time as binary addresses, round-robin.
// Latency: 2 edges from req to out_valid; one address per cycle sustained while out_ready is high.
// Backpressure: out_valid/out_addr hold while out_ready is low; new requests keep merging into pending.
// Ports: clk, rst (async, active-high), req[N] in; out_addr[AW], out_valid out; out_ready in;
//        pending[N], busy out.
module request_encoder
   import request_encoder_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [AW-1:0] out_addr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  pending,
   output logic          busy
);

   state_t        state_q,    state_d;
   logic [N-1:0]  pending_q,  pending_d;
   logic [AW-1:0] ptr_q,      ptr_d;
   logic [AW-1:0] out_addr_q, out_addr_d;

   logic [AW-1:0] pick_idx;
   logic          pick_found;
   logic          load;
   logic [N-1:0]  load_mask;

   // Selection sees only registered pending; same-cycle req waits one edge.
   rr_pick #(
      .N  (N),
      .AW (AW)
   ) u_rr_pick (
      .vec   (pending_q),
      .start (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      out_addr_d = out_addr_q;
      load       = 1'b0;
      load_mask  = '0;

      case (state_q)
         EMPTY: begin
            if (pick_found) begin
               load    = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            // Handshake completes this edge; refill in the same edge if possible.
            if (out_ready) begin
               if (pick_found) begin
                  load = 1'b1;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      if (load) begin
         out_addr_d = pick_idx;
         load_mask  = N'(1) << pick_idx;
         ptr_d      = (pick_idx == AW'(N-1)) ? '0 : pick_idx + 1'b1;
      end

      // req is OR'd after the clear so a collision on the loaded bit re-arms it.
      pending_d = (pending_q & ~load_mask) | req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         pending_q  <= '0;
         ptr_q      <= '0;
         out_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         out_addr_q <= out_addr_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_addr  = out_addr_q;
   assign pending   = pending_q;
   assign busy      = (|pending_q) | out_valid;

endmodule

// File: doc/request_encoder.md
# request_encoder

Round-robin request encoder: collects one-hot/multi-hot request events from up to N requesters and emits them one at a time as binary addresses over a valid/ready handshake. It is the inverse of the address-decoder path, turning select lines back into an address. It sits between the requester bank and the address bus that drives the decoder. Requests are sticky, so a single-cycle pulse is never lost while the output is stalled.

## Interface
- N, default 8: number of request lines; N >= 2, need not be a power of two.
- AW, default $clog2(N) = 3: address width.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  request events; bit i high at an edge registers a request for address i.
- out_addr  output  AW  encoded address of the granted request.
- out_valid  output  1  out_addr holds a valid address.
- out_ready  input  1  consumer accepts out_addr when high together with out_valid.
- pending  output  N  registered outstanding requests not yet loaded into the output.
- busy  output  1  |pending | out_valid.

## Operation
- Reset values: pending = 0, out_valid = 0, out_addr = 0, internal pointer ptr = 0.
- Pending update each edge: pending_next = (pending & ~load_mask) | req.
  - load_mask is the one-hot mask of the bit loaded this edge, or 0 if nothing loads.
  - A req bit already pending merges; there is no counting.
- Selection: the first set bit of pending, searching ptr, ptr+1, …, N-1, 0, …, ptr-1. This is combinational and uses the registered pending only; the same-cycle req is not included.
- Output register state machine:
  - EMPTY (out_valid = 0), pending != 0: load the selected index into out_addr, set out_valid, go to FULL.
  - EMPTY, pending == 0: stay in EMPTY; out_addr holds its last value.
  - FULL, out_ready = 0: hold. out_addr and out_valid do not change, and no load occurs.
  - FULL, out_ready = 1, pending != 0: the handshake completes and the next selected index loads in the same edge. Stay in FULL.
  - FULL, out_ready = 1, pending == 0: the handshake completes, out_valid goes to 0, go to EMPTY.
- On every load of index i: ptr becomes i+1, wrapping N-1 to 0.
- out_valid never drops without a completed handshake, except on reset.
- Simultaneous events:
  - If req[i] is high on the edge that loads i, pending[i] stays 1. It is a new event and is presented again later.
- Reset mid-operation: all pending requests and any held output are discarded immediately (asynchronously). No address is emitted after release until a new req arrives.

## Timing
- Request latency: req[i] sampled at edge E0 sets pending[i] after E0. If the output is free, out_valid = 1 and out_addr = i after E1. This is 2 edges from request to valid.
- Throughput: one address per cycle while out_ready = 1 and pending != 0.
- out_ready has a combinational path only into next-state logic. No output depends combinationally on any input.
- All outputs are registered, except busy, which is an OR of registers.

## Structure
- Package request_encoder_pkg: default N and AW constants, and the state enum {EMPTY, FULL}.
- Sub-module rr_pick: combinational round-robin first-one finder.
  - Inputs: N-bit vector, AW-bit start pointer.
  - Outputs: AW-bit index, found flag.
  - It is instantiated once and is reusable by future arbiters.
- The top level holds the pending register, ptr, output register and state machine.

## Test plan
- Reset: drive rst high with random req → out_valid = 0, out_addr = 0, pending = 0, busy = 0; these persist until one edge after release with req = 0.
- Single pulse: req = 8'b0010_0000 for one edge, out_ready = 1 → out_valid = 1 and out_addr = 5 exactly 2 edges later for one cycle; pending then 0 and busy = 0.
- Burst ordering: req = 8'b1010_0101 for one edge from ptr = 0, out_ready = 1 → addresses 0, 2, 5, 7 on consecutive cycles, then out_valid = 0.
- Backpressure and wrap:
  - Stimulus: out_ready = 0; pulse req[3]; then pulse req[1] while stalled.
  - Response: out_addr = 3 is held stable for 5 cycles and pending = 8'b0000_0010.
  - Stimulus: raise out_ready.
  - Response: 3 is accepted, then 1 is presented (search wraps from ptr = 4).
- Collision: pulse req[2] on the same edge that loads address 2 → address 2 is presented twice in succession.
- Reset mid-operation:
  - Stimulus: pending = 8'hFF, out_valid = 1; assert rst between edges.
  - Response: outputs are zero before the next edge; after release with req = 0, no out_valid for 10 cycles.
